// File: rtl/hls_ap_bus_mem_adapter.sv
// ap_bus mem0 downstream adapter: splits burst requests into single-word memory
// reads/writes and returns read data through a credit-protected in-order FIFO.
module hls_ap_bus_mem_adapter #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int RSP_FIFO_DEPTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  req_write,
  input  logic                  req_din,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [ADDR_WIDTH-1:0] size,
  input  logic [DATA_WIDTH-1:0] dataout,
  output logic                  req_full_n,
  output logic                  rsp_empty_n,
  output logic [DATA_WIDTH-1:0] datain,
  input  logic                  rsp_read,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  err
);
  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = RSP_FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_ISSUE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr, remaining;
  logic [CW-1:0]         outstanding, fifo_count;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic                  credit_ok, wr_fire, rd_fire, rsp_push, rsp_pop, last_beat;

  // Outstanding reads plus buffered words never exceed the FIFO, so a push always fits
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
  assign wr_fire   = mem_wr_valid & mem_wr_ready;
  assign rd_fire   = mem_rd_valid & mem_rd_ready;
  assign rsp_push  = mem_rsp_valid & (outstanding != '0);
  assign rsp_pop   = rsp_read & (fifo_count != '0);
  assign last_beat = (remaining == ADDR_WIDTH'(1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_write && size != '0) state_nx = req_din ? WR_DATA : RD_ISSUE;
      WR_DATA:  if (wr_fire && last_beat) state_nx = IDLE;
      RD_ISSUE: if (rd_fire && last_beat) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_full_n   = 1'b0;
    mem_wr_valid = 1'b0;
    mem_rd_valid = 1'b0;
    case (state)
      IDLE:     req_full_n = 1'b1;
      WR_DATA: begin
        req_full_n   = mem_wr_ready;
        mem_wr_valid = req_write;
      end
      RD_ISSUE: mem_rd_valid = credit_ok;
      default:  req_full_n = 1'b0;
    endcase
  end

  assign mem_wr_addr = cur_addr;
  assign mem_wr_data = dataout;
  assign mem_rd_addr = cur_addr;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (state == IDLE && req_write) begin
      cur_addr  <= address;
      remaining <= size;
    end else if (wr_fire || rd_fire) begin
      cur_addr  <= cur_addr + ADDR_WIDTH'(1);
      remaining <= remaining - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err         <= 1'b0;
    end else begin
      case ({rd_fire, rsp_push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({rsp_push, rsp_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (rsp_push) wr_ptr <= wr_ptr + PW'(1);
      if (rsp_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (mem_rsp_valid && outstanding == '0) err <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (rsp_push) fifo_mem[wr_ptr] <= mem_rsp_data;
  end

  assign rsp_empty_n = (fifo_count != '0);
  assign datain      = fifo_mem[rd_ptr];
endmodule
